// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared states, mode encodings and segment codes for the RAM read scanner
package scanner_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;
    localparam logic [1:0] MODE_STEP    = 2'b10;
    localparam logic [1:0] MODE_REFRESH = 2'b11;

    // Active-low segments, bit7 = dp, bits6:0 = g..a; index 0 is the last entry.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] LETTER_H  = 8'h89;
    localparam logic [7:0] LETTER_A  = 8'h88;
    localparam logic [7:0] LETTER_S  = 8'h92;
    localparam logic [7:0] LETTER_R  = 8'hAF;

    function automatic logic [7:0] mode_letter(input logic [1:0] m);
        case (m)
            MODE_HOLD:    mode_letter = LETTER_H;
            MODE_AUTO:    mode_letter = LETTER_A;
            MODE_STEP:    mode_letter = LETTER_S;
            default:      mode_letter = LETTER_R;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low seven-segment decoder
module hex_to_seg
    import scanner_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/ram_read_scanner.sv
// rtl/ram_read_scanner.sv - scans a RAM read port and shows address/data on four seven-segment digits
module ram_read_scanner
    import scanner_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DIV    = 50_000_000
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              step_btn,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        HEX0,
    output logic [7:0]        HEX1,
    output logic [7:0]        HEX2,
    output logic [7:0]        HEX3
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [ADDR_W-1:0]  w_cur_addr_nxt;
    logic [ADDR_W-1:0]  r_addr_q;
    logic [DATA_W-1:0]  r_data_q;
    logic               r_valid_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_mode;
    logic [2:0]         r_sync;
    logic               w_step_pulse;
    logic               w_capture;
    logic               w_step_wait;
    logic [7:0]         w_seg_lo;
    logic [7:0]         w_seg_hi;
    logic [7:0]         w_seg_addr;
    logic [7:0]         r_hex0;
    logic [7:0]         r_hex1;
    logic [7:0]         r_hex2;
    logic [7:0]         r_hex3;

    assign rd_addr      = r_cur_addr;
    assign w_step_pulse = r_sync[1] & ~r_sync[2];
    assign w_step_wait  = (r_state == ST_WAIT) && (r_mode == MODE_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ISSUE;
            r_cur_addr <= '0;
            r_cnt      <= '0;
            r_mode     <= MODE_HOLD;
            r_sync     <= '0;
            r_data_q   <= '0;
            r_addr_q   <= '0;
            r_valid_q  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mode     <= mode;
            r_sync     <= {r_sync[1:0], step_btn};
            if (w_capture) begin
                r_data_q  <= rd_data;
                r_addr_q  <= r_cur_addr;
                r_valid_q <= 1'b1;
            end
        end
    end

    // A mode change seen in WAIT only resets the counter; the new rule runs next clock.
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_cnt_nxt      = r_cnt;
        w_capture      = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mode != r_mode) begin
                    w_cnt_nxt = '0;
                end else begin
                    case (r_mode)
                        MODE_AUTO: begin
                            if (r_cnt == CNT_W'(DIV - 3)) begin
                                w_cnt_nxt      = '0;
                                w_cur_addr_nxt = r_cur_addr + ADDR_W'(1);
                                w_state_nxt    = ST_ISSUE;
                            end else begin
                                w_cnt_nxt = r_cnt + CNT_W'(1);
                            end
                        end
                        MODE_STEP: begin
                            if (w_step_pulse) begin
                                w_cur_addr_nxt = r_cur_addr + ADDR_W'(1);
                                w_state_nxt    = ST_ISSUE;
                            end
                        end
                        MODE_REFRESH: begin
                            w_state_nxt = ST_ISSUE;
                        end
                        default: begin
                            w_state_nxt = ST_WAIT;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase
    end

    hex_to_seg u_seg_lo (
        .i_nibble (4'(r_data_q)),
        .o_seg    (w_seg_lo)
    );

    hex_to_seg u_seg_hi (
        .i_nibble (4'(r_data_q >> 4)),
        .o_seg    (w_seg_hi)
    );

    hex_to_seg u_seg_addr (
        .i_nibble (4'(r_addr_q)),
        .o_seg    (w_seg_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex0 <= SEG_BLANK;
            r_hex1 <= SEG_BLANK;
            r_hex2 <= SEG_BLANK;
            r_hex3 <= SEG_BLANK;
        end else begin
            r_hex3 <= mode_letter(mode);
            if (r_valid_q) begin
                r_hex0 <= w_seg_lo;
                r_hex1 <= w_seg_hi;
                r_hex2 <= {w_seg_addr[7] & ~w_step_wait, w_seg_addr[6:0]};
            end else begin
                r_hex0 <= SEG_BLANK;
                r_hex1 <= SEG_BLANK;
                r_hex2 <= SEG_BLANK;
            end
        end
    end

    assign HEX0 = r_hex0;
    assign HEX1 = r_hex1;
    assign HEX2 = r_hex2;
    assign HEX3 = r_hex3;

endmodule

// File: tb/tb_ram_read_scanner.sv
// tb/tb_ram_read_scanner.sv - randomized self-checking bench for ram_read_scanner
module tb_ram_read_scanner;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       step_btn;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] hex0, hex1, hex2, hex3;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one clock after the address is sampled.
    always @(posedge clk) rd_data <= mem[rd_addr];

    ram_read_scanner #(.ADDR_W(4), .DATA_W(8), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .step_btn (step_btn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3)
    );

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_display(input string tag, input logic [3:0] a, input logic dp_lit);
        logic [7:0] d;
        logic [7:0] e2;
        d  = mem[a];
        e2 = seg7(a);
        if (dp_lit) e2[7] = 1'b0;
        check({tag, "_hex2"}, 32'(hex2), 32'(e2));
        check({tag, "_hex0"}, 32'(hex0), 32'(seg7(d[3:0])));
        check({tag, "_hex1"}, 32'(hex1), 32'(seg7(d[7:4])));
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_hex0"}, 32'(hex0), 32'hFF);
        check({tag, "_hex1"}, 32'(hex1), 32'hFF);
        check({tag, "_hex2"}, 32'(hex2), 32'hFF);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hold_at;
        logic [3:0] a;
        logic [7:0] newv;
        int         len;

        rst_n    = 1'b1;
        mode     = 2'b01;
        step_btn = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16);
        mem[0] = 8'h3C;

        // Reset values, then AUTO scanning with wrap; address n shows from edge 3+DIV*n.
        #2 rst_n = 1'b0;
        #1;
        check_blank("reset");
        check("reset_hex3", 32'(hex3), 32'hFF);
        check("reset_rd_addr", 32'(rd_addr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            check("auto_rd_addr", 32'(rd_addr), 32'((k / DIV) % 16));
            if (k < 3) check_blank("auto_early");
            else       check_display("auto", 4'(((k - 3) / DIV) % 16), 1'b0);
            if (k == 3) check("reset_release_hex3", 32'(hex3), 32'h88);
        end

        // HOLD: freeze at a random address; step presses must be ignored.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mode    = 2'b01;
        hold_at = 4'($urandom_range(1, 14));
        reset_pulse();
        tick(3 + DIV * int'(hold_at));
        check_display("auto_before_hold", hold_at, 1'b0);
        mode = 2'b00;
        for (int c = 1; c <= 50; c++) begin
            if (c == 10 || c == 30) step_btn = 1'b1;
            if (c == 13 || c == 32) step_btn = 1'b0;
            tick(1);
            check("hold_rd_addr", 32'(rd_addr), 32'(hold_at));
            check_display("hold", hold_at, 1'b0);
            if (c >= 2) check("hold_hex3", 32'(hex3), 32'h89);
        end

        // STEP: no queued step from HOLD, then exactly one advance per press.
        a    = hold_at;
        mode = 2'b10;
        tick(4);
        check_display("step_ready", a, 1'b1);
        check("step_hex3", 32'(hex3), 32'h92);
        for (int p = 0; p < 3; p++) begin
            len = (p == 1) ? 2 : int'($urandom_range(3, 6));
            step_btn = 1'b1;
            tick(len);
            step_btn = 1'b0;
            tick(10);
            a = a + 4'd1;
            check_display("step", a, 1'b1);
            check("step_rd_addr", 32'(rd_addr), 32'(a));
        end

        // REFRESH: new RAM contents appear without moving the address.
        mode = 2'b11;
        tick(5);
        check("refresh_hex3", 32'(hex3), 32'hAF);
        check_display("refresh_idle", a, 1'b0);
        newv   = (mem[a] == 8'hAA) ? 8'h55 : 8'hAA;
        mem[a] = newv;
        tick(5);
        check_display("refresh_new", a, 1'b0);
        check("refresh_rd_addr", 32'(rd_addr), 32'(a));

        // Reset during the CAPTURE of address 7 (edges 28..29 after release).
        mode   = 2'b01;
        mem[0] = 8'($urandom);
        reset_pulse();
        tick(29);
        check("midread_rd_addr", 32'(rd_addr), 32'h7);
        check_display("midread_prev", 4'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        check_blank("midread_reset");
        check("midread_hex3", 32'(hex3), 32'hFF);
        check("midread_reset_rd_addr", 32'(rd_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check_blank("midread_k2");
        tick(1);
        check_display("midread_first", 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
